// File: rtl/imem_loader.sv
// Instruction-store writer: parses SYNC/COUNT/data/CHK frames from a byte stream into a
// word store, holds the core until a checksum-verified program is loaded.
module imem_loader #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic [31:0] PC,
  output logic [31:0] Instr,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [7:0]  words_written
);

  typedef enum logic [2:0] {
    StIdle, StCount, StData, StWrite, StCheck, StDone, StError
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  n_q, n_d;
  logic [7:0]  ww_q, ww_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic        accept;
  logic [7:0]  ww_inc;

  logic [31:0] mem_q [DEPTH];

  assign in_ready      = (state_q != StWrite);
  assign accept        = in_valid && in_ready;
  assign ww_inc        = ww_q + 8'd1;
  assign cpu_hold      = hold_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
  assign words_written = ww_q;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    chk_d   = chk_q;
    word_d  = word_q;
    n_d     = n_q;
    ww_d    = ww_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle, StDone, StError: begin
        // Flags from the previous frame persist until a new SYNC arrives.
        if (accept && in_byte == SYNC) begin
          state_d = StCount;
          chk_d   = 8'd0;
          ww_d    = 8'd0;
          lane_d  = 2'd0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StCount: begin
        if (accept) begin
          chk_d = chk_q ^ in_byte;
          if (in_byte == 8'd0 || {24'd0, in_byte} > DEPTH) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            n_d     = in_byte;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d = {word_q[23:0], in_byte};
          chk_d  = chk_q ^ in_byte;
          lane_d = lane_q + 2'd1;
          if (lane_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        mem_we  = 1'b1;
        ww_d    = ww_inc;
        lane_d  = 2'd0;
        state_d = (ww_inc == n_q) ? StCheck : StData;
      end
      StCheck: begin
        if (accept) begin
          if (in_byte == chk_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      lane_q  <= 2'd0;
      chk_q   <= 8'd0;
      word_q  <= 32'd0;
      n_q     <= 8'd0;
      ww_q    <= 8'd0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      chk_q   <= chk_d;
      word_q  <= word_d;
      n_q     <= n_d;
      ww_q    <= ww_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Store is deliberately not reset so a program survives a core/loader reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ww_q[ADDR_W-1:0]] <= word_q;
  end

  assign Instr = mem_q[ADDR_W'((PC >> 2) % DEPTH)];

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: framing, checksum, errors, reset, backpressure.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [7:0]  words_written;

  int errors  = 0;
  int checks  = 0;
  int gap_max = 0;

  imem_loader #(
    .DEPTH (32),
    .ADDR_W(5),
    .SYNC  (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .PC           (PC),
    .Instr        (Instr),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  // Offers one byte, waits (bounded) for in_ready, returns #1 after the consuming edge.
  task automatic send(input logic [7:0] b);
    int t;
    int g;
    in_valid = 1'b1;
    in_byte  = b;
    t = 0;
    while (!in_ready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    for (int i = 0; i < g; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_pc(input logic [31:0] a);
    PC = a;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold got=%b exp=1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL rst_load_done got=%b exp=0", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL rst_load_err got=%b exp=0", load_err); end
    checks++; if (words_written !== 8'd0) begin errors++; $display("FAIL rst_ww got=%0d exp=0", words_written); end
  endtask

  task automatic test_good_frame;
    send(8'hA5); send(8'h01); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL good_write_ready got=%b exp=0", in_ready); end
    checks++; if (words_written !== 8'd0) begin errors++; $display("FAIL good_ww_pre got=%0d exp=0", words_written); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL good_hold_pre got=%b exp=1", cpu_hold); end
    send(8'h2C);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL good_done got=%b exp=1", load_done); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL good_err got=%b exp=0", load_err); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL good_hold got=%b exp=0", cpu_hold); end
    checks++; if (words_written !== 8'd1) begin errors++; $display("FAIL good_ww got=%0d exp=1", words_written); end
    read_pc(32'd0);
    checks++; if (Instr !== 32'h2008_0005) begin errors++; $display("FAIL good_instr got=%h exp=20080005", Instr); end
  endtask

  task automatic test_two_words;
    gap_max = 3;
    send(8'hA5); send(8'h02);
    send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'h01); send(8'h09); send(8'h50); send(8'h20);
    send(8'h57);  // XOR of 02 20 08 00 05 01 09 50 20
    gap_max = 0;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL two_done got=%b exp=1", load_done); end
    checks++; if (words_written !== 8'd2) begin errors++; $display("FAIL two_ww got=%0d exp=2", words_written); end
    read_pc(32'd4);
    checks++; if (Instr !== 32'h0109_5020) begin errors++; $display("FAIL two_instr1 got=%h exp=01095020", Instr); end
    read_pc(32'd0);
    checks++; if (Instr !== 32'h2008_0005) begin errors++; $display("FAIL two_instr0 got=%h exp=20080005", Instr); end
  endtask

  task automatic test_bad_chk;
    send(8'hA5); send(8'h01); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    send(8'h2D);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL badchk_err got=%b exp=1", load_err); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL badchk_done got=%b exp=0", load_done); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL badchk_hold got=%b exp=1", cpu_hold); end
    read_pc(32'd0);
    checks++; if (Instr !== 32'h2008_0005) begin errors++; $display("FAIL badchk_instr got=%h exp=20080005", Instr); end
  endtask

  task automatic test_bad_count;
    send(8'hA5); send(8'h00);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL cnt0_err got=%b exp=1", load_err); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL cnt0_hold got=%b exp=1", cpu_hold); end
    send(8'h01); send(8'h20); send(8'h08); send(8'h00); send(8'h05); send(8'h2C);
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL cnt0_ignored_done got=%b exp=0", load_done); end
    checks++; if (words_written !== 8'd0) begin errors++; $display("FAIL cnt0_ignored_ww got=%0d exp=0", words_written); end
    send(8'hA5);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL resync_err got=%b exp=0", load_err); end
    send(8'h21);
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL cnt33_err got=%b exp=1", load_err); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL cnt33_done got=%b exp=0", load_done); end
  endtask

  task automatic test_reset_mid_frame;
    send(8'hA5); send(8'h01); send(8'h20); send(8'h08); send(8'h00); send(8'h05); send(8'h2C);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL mid_pre_done got=%b exp=1", load_done); end
    send(8'hA5); send(8'h01); send(8'hDE); send(8'hAD);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL mid_hold got=%b exp=1", cpu_hold); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", load_done); end
    checks++; if (words_written !== 8'd0) begin errors++; $display("FAIL mid_ww got=%0d exp=0", words_written); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
    read_pc(32'd0);
    checks++; if (Instr !== 32'h2008_0005) begin errors++; $display("FAIL mid_instr got=%h exp=20080005", Instr); end
  endtask

  task automatic test_back_to_back;
    send(8'h00); send(8'hFF);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL junk_err got=%b exp=0", load_err); end
    send(8'hA5); send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    read_pc(32'd0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_write_ready got=%b exp=0", in_ready); end
    checks++; if (Instr !== 32'h2008_0005) begin errors++; $display("FAIL write_old got=%h exp=20080005", Instr); end
    in_valid = 1'b1;
    in_byte  = 8'h45;  // XOR of 01 11 22 33 44
    @(posedge clk);
    #1;
    checks++; if (Instr !== 32'h1122_3344) begin errors++; $display("FAIL write_new got=%h exp=11223344", Instr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL check_ready got=%b exp=1", in_ready); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL pend_early_done got=%b exp=0", load_done); end
    checks++; if (words_written !== 8'd1) begin errors++; $display("FAIL pend_ww got=%0d exp=1", words_written); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL pend_done got=%b exp=1", load_done); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL pend_hold got=%b exp=0", cpu_hold); end
  endtask

  task automatic test_full_depth;
    logic [7:0]  chk;
    logic [7:0]  b;
    logic [31:0] w;
    logic [31:0] w2;
    logic [31:0] w31;
    chk = 8'h20;
    send(8'hA5); send(8'h20);
    for (int i = 0; i < 32; i++) begin
      b = 8'(i);
      w = {b, ~b, b ^ 8'h0F, 8'h5A};
      if (i == 2) w2 = w;
      if (i == 31) w31 = w;
      for (int k = 3; k >= 0; k--) begin
        chk = chk ^ w[k*8 +: 8];
        send(w[k*8 +: 8]);
      end
    end
    send(chk);
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL full_done got=%b exp=1", load_done); end
    checks++; if (words_written !== 8'd32) begin errors++; $display("FAIL full_ww got=%0d exp=32", words_written); end
    read_pc(32'd124);
    checks++; if (Instr !== w31) begin errors++; $display("FAIL full_last got=%h exp=%h", Instr, w31); end
    read_pc(32'd139);  // index 34 wraps to 2, low bits ignored
    checks++; if (Instr !== w2) begin errors++; $display("FAIL full_wrap got=%h exp=%h", Instr, w2); end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    PC       = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_good_frame();
    test_two_words();
    test_bad_chk();
    test_bad_count();
    test_reset_mid_frame();
    test_back_to_back();
    test_full_depth();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
